// File: rtl/stm_gain_sweep.sv
// stm_gain_sweep
// Reads one gain frame from the gain-STM memory port and streams it to the
// drive pipeline. On START, the index and segment are latched and GAIN_ADDR
// sweeps 0..DEPTH-1. A short (valid, addr) delay line lines up each issued
// address with its VALUE word, which arrives MEM_LATENCY cycles later. The
// matching 16-bit lane is then registered onto INTENSITY/PHASE/TR_IDX.
// A START that arrives while busy is held in a one-deep pending slot, where
// the newest request replaces any older one. That request launches on the
// DONE edge, so consecutive sweeps run with no idle gap in BUSY.
module stm_gain_sweep #(
  parameter int DEPTH       = 249,
  parameter int MEM_LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [9:0]  IDX_IN,
  input  logic        SEGMENT_IN,
  output logic [9:0]  GAIN_IDX,
  output logic [7:0]  GAIN_ADDR,
  output logic        SEGMENT,
  input  logic [63:0] VALUE,
  output logic [7:0]  INTENSITY,
  output logic [7:0]  PHASE,
  output logic [7:0]  TR_IDX,
  output logic        DOUT_VALID,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;

  // One-deep request slot, filled by START while a sweep is running.
  logic       pend_valid;
  logic [9:0] pend_idx;
  logic       pend_seg;

  // Delay line: stage MEM_LATENCY-1 lines up with the VALUE word on the bus.
  logic [MEM_LATENCY-1:0] pipe_valid;
  logic [7:0]             pipe_addr [MEM_LATENCY];

  logic       tail_valid;
  logic [7:0] tail_addr;
  logic [15:0] lane_word;

  // Next sweep to launch at the DONE edge. A START in that same cycle wins.
  logic       next_valid;
  logic [9:0] next_idx;
  logic       next_seg;

  assign tail_valid = pipe_valid[MEM_LATENCY-1];
  assign tail_addr  = pipe_addr[MEM_LATENCY-1];

  assign next_valid = START | pend_valid;
  assign next_idx   = START ? IDX_IN     : pend_idx;
  assign next_seg   = START ? SEGMENT_IN : pend_seg;

  // Sweep control: state, address counter, latched request and BUSY.
  // NOTE: every state register uses non-blocking assignment, so all of them
  // update together at the edge and no block can see another's new value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      GAIN_IDX  <= 10'd0;
      SEGMENT   <= 1'b0;
      GAIN_ADDR <= 8'd0;
      BUSY      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            state     <= ISSUE;
            GAIN_IDX  <= IDX_IN;
            SEGMENT   <= SEGMENT_IN;
            GAIN_ADDR <= 8'd0;
            BUSY      <= 1'b1;
          end
        end
        ISSUE: begin
          if (GAIN_ADDR == LAST_ADDR) begin
            state     <= DRAIN;
            GAIN_ADDR <= 8'd0;
          end else begin
            GAIN_ADDR <= GAIN_ADDR + 8'd1;
          end
        end
        DRAIN: begin
          // DONE marks the final output, so the sweep is over at this edge.
          if (DONE) begin
            if (next_valid) begin
              state     <= ISSUE;
              GAIN_IDX  <= next_idx;
              SEGMENT   <= next_seg;
              GAIN_ADDR <= 8'd0;
            end else begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          GAIN_ADDR <= 8'd0;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end

  // Pending request slot: the newest START while busy wins. It is emptied at
  // the DONE edge because that edge launches it, or a same-cycle START.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_valid <= 1'b0;
      pend_idx   <= 10'd0;
      pend_seg   <= 1'b0;
    end else if (state == DRAIN && DONE) begin
      pend_valid <= 1'b0;
    end else if (START && state != IDLE) begin
      pend_valid <= 1'b1;
      pend_idx   <= IDX_IN;
      pend_seg   <= SEGMENT_IN;
    end
  end

  // Delay line that follows each issued address through the memory latency.
  // NOTE: the delay line is reset even though it is storage. A stale valid
  // bit left over from an aborted sweep would otherwise emit a sample.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pipe_valid <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) pipe_addr[i] <= 8'd0;
    end else begin
      pipe_valid[0] <= (state == ISSUE);
      pipe_addr[0]  <= GAIN_ADDR;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_addr[i]  <= pipe_addr[i-1];
      end
    end
  end

  // Lane select: each 64-bit word packs four transducers, lane = addr % 4.
  // NOTE: lane_word gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    lane_word = 16'd0;
    case (tail_addr[1:0])
      2'd0: lane_word = VALUE[15:0];
      2'd1: lane_word = VALUE[31:16];
      2'd2: lane_word = VALUE[47:32];
      2'd3: lane_word = VALUE[63:48];
      default: lane_word = 16'd0;
    endcase
  end

  // Output register. The data fields keep their last value while not valid.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      INTENSITY  <= 8'd0;
      PHASE      <= 8'd0;
      TR_IDX     <= 8'd0;
      DOUT_VALID <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      DOUT_VALID <= tail_valid;
      DONE       <= tail_valid && (tail_addr == LAST_ADDR);
      if (tail_valid) begin
        INTENSITY <= lane_word[15:8];
        PHASE     <= lane_word[7:0];
        TR_IDX    <= tail_addr;
      end
    end
  end

endmodule

// File: tb/tb_stm_gain_sweep.sv
// tb_stm_gain_sweep
// Directed scenarios drive stm_gain_sweep against a two-cycle memory model.
// Each sweep's expected outputs, with the exact cycle each should appear in,
// go onto a scoreboard queue when the sweep is requested. A negedge monitor
// pops and compares entries as DOUT_VALID arrives.
module tb_stm_gain_sweep;

  localparam int DEPTH = 249;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [9:0]  IDX_IN;
  logic        SEGMENT_IN;
  logic [9:0]  GAIN_IDX;
  logic [7:0]  GAIN_ADDR;
  logic        SEGMENT;
  logic [63:0] VALUE = 64'd0;
  logic [7:0]  INTENSITY;
  logic [7:0]  PHASE;
  logic [7:0]  TR_IDX;
  logic        DOUT_VALID;
  logic        BUSY;
  logic        DONE;

  stm_gain_sweep #(.DEPTH(DEPTH), .MEM_LATENCY(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .IDX_IN    (IDX_IN),
    .SEGMENT_IN(SEGMENT_IN),
    .GAIN_IDX  (GAIN_IDX),
    .GAIN_ADDR (GAIN_ADDR),
    .SEGMENT   (SEGMENT),
    .VALUE     (VALUE),
    .INTENSITY (INTENSITY),
    .PHASE     (PHASE),
    .TR_IDX    (TR_IDX),
    .DOUT_VALID(DOUT_VALID),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;
  int unsigned seed = 0;

  always @(posedge CLK) edge_cnt++;

  typedef struct {
    logic [7:0] tr;
    logic [7:0] inten;
    logic [7:0] ph;
    logic       last;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  // Monitor-side watches, cleared and read by the directed steps.
  int         max_addr   = 0;
  int         hold_err   = 0;
  int         busy_gaps  = 0;
  logic       hold_watch = 1'b0;
  logic       busy_watch = 1'b0;
  logic [9:0] hold_idx   = 10'd0;
  logic       hold_seg   = 1'b0;
  logic       idx7_seen  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Gain table contents. (seg 0, idx 42, tr 0..3) holds a known lane pattern.
  function automatic logic [15:0] gain_data(input logic seg, input logic [9:0] idx, input int tr);
    logic [7:0]  trb;
    int unsigned x;
    trb = 8'(tr);
    if (!seg && idx == 10'd42 && tr < 4) return {8'(10 * (tr + 1)), 8'(tr + 1)};
    x = 32'({seg, idx, trb}) ^ seed;
    x = x * 32'h9E3779B1;
    x = x ^ (x >> 15);
    x = x * 32'h85EBCA6B;
    x = x ^ (x >> 13);
    return x[15:0];
  endfunction

  function automatic logic [63:0] mem_word(input logic seg, input logic [9:0] idx, input logic [7:0] addr);
    logic [63:0] w;
    int base;
    base = int'({addr[7:2], 2'b00});
    for (int k = 0; k < 4; k++) w[16*k +: 16] = gain_data(seg, idx, base + k);
    return w;
  endfunction

  // Memory model: VALUE two cycles after the address.
  logic [18:0] rd_q = 19'd0;
  always @(posedge CLK) begin
    rd_q  <= {SEGMENT, GAIN_IDX, GAIN_ADDR};
    VALUE <= mem_word(rd_q[18], rd_q[17:8], rd_q[7:0]);
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      if (DOUT_VALID) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'(DOUT_VALID), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("tr_idx",      64'(TR_IDX),    64'(e.tr));
          check("intensity",   64'(INTENSITY), 64'(e.inten));
          check("phase",       64'(PHASE),     64'(e.ph));
          check("done",        64'(DONE),      64'(e.last));
          check("valid_cycle", 64'(edge_cnt),  64'(e.cyc));
        end
      end else begin
        check("done_without_valid", 64'(DONE), 64'd0);
      end
      if (BUSY && int'(GAIN_ADDR) > max_addr) max_addr = int'(GAIN_ADDR);
      if (hold_watch && (GAIN_IDX !== hold_idx || SEGMENT !== hold_seg)) hold_err++;
      if (busy_watch && BUSY !== 1'b1) busy_gaps++;
      if (BUSY && GAIN_IDX == 10'd7) idx7_seen = 1'b1;
    end
  end

  // Queue one sweep. Its edge 0 is e0, and tr k is valid at edge count e0+3+k.
  task automatic push_sweep(input logic [9:0] idx, input logic seg, input int e0);
    exp_t e;
    logic [15:0] d;
    for (int k = 0; k < DEPTH; k++) begin
      d       = gain_data(seg, idx, k);
      e.tr    = 8'(k);
      e.inten = d[15:8];
      e.ph    = d[7:0];
      e.last  = (k == DEPTH - 1);
      e.cyc   = e0 + 3 + k;
      exp_q.push_back(e);
    end
  endtask

  // Called #1 after an edge; returns #1 after the edge that sampled START.
  task automatic start_req(input logic [9:0] idx, input logic seg, output int e0);
    START      = 1'b1;
    IDX_IN     = idx;
    SEGMENT_IN = seg;
    @(posedge CLK);
    #1;
    START = 1'b0;
    e0    = edge_cnt;
  endtask

  // Move to #1 inside cycle n of the sweep whose START edge was e0.
  task automatic goto_cycle(input int e0, input int n);
    while (edge_cnt < e0 + n - 1) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_zero(input string ph);
    check({ph, "_gain_idx"},  64'(GAIN_IDX),   64'd0);
    check({ph, "_gain_addr"}, 64'(GAIN_ADDR),  64'd0);
    check({ph, "_segment"},   64'(SEGMENT),    64'd0);
    check({ph, "_intensity"}, 64'(INTENSITY),  64'd0);
    check({ph, "_phase"},     64'(PHASE),      64'd0);
    check({ph, "_tr_idx"},    64'(TR_IDX),     64'd0);
    check({ph, "_valid"},     64'(DOUT_VALID), 64'd0);
    check({ph, "_busy"},      64'(BUSY),       64'd0);
    check({ph, "_done"},      64'(DONE),       64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int e1;
    int stray;

    seed       = $urandom;
    RST        = 1'b1;
    START      = 1'b0;
    IDX_IN     = 10'd0;
    SEGMENT_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_zero("reset");
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // 1: idx 5 / seg 0, timing and boundaries.
    start_req(10'd5, 1'b0, e0);
    push_sweep(10'd5, 1'b0, e0);
    check("s1_addr_c1", 64'(GAIN_ADDR), 64'd0);
    check("s1_busy_c1", 64'(BUSY),      64'd1);
    check("s1_idx_c1",  64'(GAIN_IDX),  64'd5);
    goto_cycle(e0, 2);
    check("s1_addr_c2", 64'(GAIN_ADDR), 64'd1);
    goto_cycle(e0, 3);
    check("s1_valid_c3", 64'(DOUT_VALID), 64'd0);
    goto_cycle(e0, 249);
    check("s1_addr_last", 64'(GAIN_ADDR), 64'd248);
    goto_cycle(e0, 250);
    check("s1_addr_wrap", 64'(GAIN_ADDR), 64'd0);
    check("s1_busy_drain", 64'(BUSY),     64'd1);
    goto_cycle(e0, 252);
    check("s1_done_c252", 64'(DONE), 64'd1);
    check("s1_busy_c252", 64'(BUSY), 64'd1);
    goto_cycle(e0, 253);
    check("s1_busy_c253", 64'(BUSY), 64'd0);
    check("s1_done_c253", 64'(DONE), 64'd0);
    drain(20);

    // 2: idx 1023 / seg 1, latched fields held, address bound.
    max_addr = 0;
    hold_err = 0;
    start_req(10'd1023, 1'b1, e0);
    push_sweep(10'd1023, 1'b1, e0);
    hold_idx   = 10'd1023;
    hold_seg   = 1'b1;
    hold_watch = 1'b1;
    goto_cycle(e0, 253);
    hold_watch = 1'b0;
    check("s2_hold",     64'(hold_err), 64'd0);
    check("s2_max_addr", 64'(max_addr), 64'd248);
    drain(20);

    // 3: lane select with a known pattern in tr 0..3.
    start_req(10'd42, 1'b0, e0);
    push_sweep(10'd42, 1'b0, e0);
    goto_cycle(e0, 4);
    check("s3_valid_tr0", 64'(DOUT_VALID),           64'd1);
    check("s3_tr0",       64'({INTENSITY, PHASE}),   64'h0A01);
    goto_cycle(e0, 5);
    check("s3_tr1",       64'({INTENSITY, PHASE}),   64'h1402);
    goto_cycle(e0, 6);
    check("s3_tr2",       64'({INTENSITY, PHASE}),   64'h1E03);
    goto_cycle(e0, 7);
    check("s3_tr3",       64'({INTENSITY, PHASE}),   64'h2804);
    check("s3_tridx3",    64'(TR_IDX),               64'd3);
    drain(300);

    // 4: two STARTs during a sweep of idx 3; only the last (idx 9) runs.
    idx7_seen = 1'b0;
    busy_gaps = 0;
    start_req(10'd3, 1'b0, e0);
    push_sweep(10'd3, 1'b0, e0);
    busy_watch = 1'b1;
    goto_cycle(e0, 100);
    start_req(10'd7, 1'b0, e1);
    goto_cycle(e0, 150);
    start_req(10'd9, 1'b0, e1);
    push_sweep(10'd9, 1'b0, e0 + 252);
    goto_cycle(e0, 253);
    check("s4_addr_restart", 64'(GAIN_ADDR), 64'd0);
    check("s4_idx_restart",  64'(GAIN_IDX),  64'd9);
    goto_cycle(e0, 505);
    busy_watch = 1'b0;
    check("s4_busy_gaps", 64'(busy_gaps), 64'd0);
    check("s4_busy_end",  64'(BUSY),      64'd0);
    check("s4_idx7",      64'(idx7_seen), 64'd0);
    drain(20);

    // 5: START in the DONE cycle, back-to-back sweep.
    start_req(10'd11, 1'b1, e0);
    push_sweep(10'd11, 1'b1, e0);
    goto_cycle(e0, 252);
    check("s5_done", 64'(DONE), 64'd1);
    start_req(10'd12, 1'b1, e1);
    push_sweep(10'd12, 1'b1, e1);
    check("s5_addr_c1", 64'(GAIN_ADDR), 64'd0);
    check("s5_idx_c1",  64'(GAIN_IDX),  64'd12);
    check("s5_busy_c1", 64'(BUSY),      64'd1);
    goto_cycle(e1, 253);
    check("s5_busy_end", 64'(BUSY), 64'd0);
    drain(20);

    // 6: reset mid-sweep, then a fresh sweep.
    start_req(10'd20, 1'b0, e0);
    push_sweep(10'd20, 1'b0, e0);
    goto_cycle(e0, 120);
    #2;
    RST = 1'b1;
    exp_q.delete();
    #1;
    check_zero("s6_async");
    repeat (2) @(posedge CLK);
    #1;
    RST   = 1'b0;
    stray = 0;
    repeat (300) begin
      @(posedge CLK);
      #1;
      if (DOUT_VALID !== 1'b0 || DONE !== 1'b0) stray++;
    end
    check("s6_stray", 64'(stray), 64'd0);
    check("s6_busy",  64'(BUSY),  64'd0);
    start_req(10'd5, 1'b0, e0);
    push_sweep(10'd5, 1'b0, e0);
    check("s6_addr_c1", 64'(GAIN_ADDR), 64'd0);
    check("s6_busy_c1", 64'(BUSY),      64'd1);
    goto_cycle(e0, 4);
    check("s6_valid_c4", 64'(DOUT_VALID), 64'd1);
    check("s6_tr_c4",    64'(TR_IDX),     64'd0);
    goto_cycle(e0, 253);
    check("s6_busy_end", 64'(BUSY), 64'd0);
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
